turn_timer_ctrl: RTL and testbench
==================================

# turn_timer_ctrl

Turn scheduler and timeout generator for the Laboratorio3 two-player game.
- Tracks which player owns the current turn.
- Counts down a per-turn time budget in whole seconds.
- Emits the one-cycle `finished` pulse that the game state machine consumes to force a turn change.
- Sits between the player input logic and the game FSM; also drives the seconds display and a low-time warning LED.

## Interface
- `CLK_HZ`, 50_000_000, clock cycles per second tick (≥2).
- `TURN_SECONDS`, 15, turn budget in seconds (1..31).
- `WARN_SECONDS`, 5, warning threshold in seconds (< `TURN_SECONDS`).
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `new_game` in 1: synchronous clear; owner := `first_player`, state := IDLE.
- `first_player` in 1: 0 = player 1, 1 = player 2; sampled only on `new_game`.
- `start` in 1: level or pulse; begins a turn for the current owner.
- `move_done` in 1: owner completed a move; ends turn without timeout.
- `pause` in 1: freeze countdown (see Configuration).
- `finished` out 1: one-cycle timeout pulse.
- `turn_owner` out 1: current owner, 0 = P1, 1 = P2.
- `running` out 1: high while a turn is being timed.
- `seconds_left` out 5: remaining seconds, binary.
- `warn` out 1: high in RUN when `seconds_left` ≤ `WARN_SECONDS`.

## Operation
- States: IDLE, RUN, EXPIRE.
- Reset values: state IDLE, `finished` 0, `turn_owner` 0, `running` 0, `seconds_left` = `TURN_SECONDS`, `warn` 0, prescaler 0.

**IDLE**
- `seconds_left` holds `TURN_SECONDS`.
- `start` → RUN: reload `seconds_left`, clear prescaler.

**RUN**
- Prescaler counts 0..`CLK_HZ`-1; the wrap cycle is a tick.
- Tick with `seconds_left` > 1 → decrement.
- Tick with `seconds_left` == 1 → `seconds_left` := 0, go to EXPIRE.
- `move_done` → IDLE, toggle `turn_owner`, reload `seconds_left`, no `finished`.
- `start` while in RUN is ignored; no restart.

**EXPIRE**
- Lasts exactly one cycle with `finished` = 1 and `seconds_left` = 0.
- Next cycle → IDLE, toggle `turn_owner`, reload `seconds_left`.

**Priority and boundary cases**
- Priority in every state: `new_game` > `move_done` > tick > `start`.
- `move_done` in the same cycle as the final tick → `move_done` wins, no `finished`.
- `move_done` in IDLE or EXPIRE is ignored.
- `new_game` in RUN or EXPIRE → IDLE immediately, no `finished`, prescaler cleared.
- `start` held high continuously → a new turn begins on the cycle after return to IDLE.
- Reset mid-turn → all outputs return to reset values asynchronously; no pulse is emitted.

**Arithmetic**
- `seconds_left` never underflows.
- Prescaler width is $clog2(`CLK_HZ`); comparisons are unsigned.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- `start` sampled at edge E → `running` = 1 after E.
- `finished` is high for the single cycle following edge E + `TURN_SECONDS`·`CLK_HZ`, assuming no pause.
- `move_done` sampled at edge E → `running` = 0 and `turn_owner` toggled after E.
- `warn` updates in the same cycle as `seconds_left`.

## Configuration
- Macro: `TURN_TIMER_PAUSE_EN`.
- Defined:
  - `pause` = 1 in RUN freezes the prescaler and `seconds_left`.
  - `move_done` and `new_game` still act during pause.
  - Releasing `pause` resumes from the frozen prescaler value.
- Undefined:
  - `pause` port remains present but is ignored.
  - Countdown is never frozen.

## Structure
- Shared package `turn_timer_pkg`:
  - `tt_state_t` enum (IDLE, RUN, EXPIRE).
  - Owner constants `OWNER_P1` = 1'b0, `OWNER_P2` = 1'b1.
  - Width localparam for `seconds_left` (5).
- One sub-module, `tick_gen`:
  - Parameter `CLK_HZ`; inputs `clk`, `rst`, `clr`, `en`; output `tick`, a one-cycle pulse on prescaler wrap.
  - `en` is tied high when `TURN_TIMER_PAUSE_EN` is undefined.

## Test plan
Bench parameters: `CLK_HZ` = 10, `TURN_SECONDS` = 3, `WARN_SECONDS` = 1.
- Full timeout: `start` 1 cycle → `seconds_left` 3→2→1→0 at 10-cycle spacing; `finished` high exactly 1 cycle, 30 cycles after the `start` edge; `turn_owner` 0→1; back to IDLE with `seconds_left` = 3.
- Early move: `start`, then `move_done` at cycle 12 → `running` 0, `turn_owner` toggles, `finished` never asserts, `seconds_left` = 3.
- Simultaneous: `move_done` on the cycle of the final tick → no `finished`, owner toggles once.
- Warning: during RUN, `warn` rises when `seconds_left` = 1 and falls on EXPIRE.
- `new_game` with `first_player` = 1 mid-turn → IDLE, `turn_owner` = 1, no `finished`; async `rst` low mid-turn → all reset values without waiting for a clock edge.
- Pause (macro defined): `pause` for 25 cycles mid-turn → `finished` delayed by exactly 25 cycles. Macro undefined: same stimulus → `finished` at cycle 30.

Source files
------------

// File: rtl/turn_timer_pkg.sv
// rtl/turn_timer_pkg.sv - shared types and constants for the turn timer
package turn_timer_pkg;

  localparam int SECS_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPIRE = 2'd2
  } tt_state_t;

  localparam logic OWNER_P1 = 1'b0;
  localparam logic OWNER_P2 = 1'b1;

endpackage

// File: rtl/turn_timer_ctrl_if.sv
// rtl/turn_timer_ctrl_if.sv - player/game-FSM facing signals of the turn timer
interface turn_timer_ctrl_if;
  import turn_timer_pkg::*;

  logic              new_game;
  logic              first_player;
  logic              start;
  logic              move_done;
  logic              pause;
  logic              finished;
  logic              turn_owner;
  logic              running;
  logic [SECS_W-1:0] seconds_left;
  logic              warn;

  modport master (
    output new_game, first_player, start, move_done, pause,
    input  finished, turn_owner, running, seconds_left, warn
  );

  modport slave (
    input  new_game, first_player, start, move_done, pause,
    output finished, turn_owner, running, seconds_left, warn
  );

endinterface

// File: rtl/turn_timer_ctrl_tick_gen.sv
// rtl/turn_timer_ctrl_tick_gen.sv - one-second prescaler, tick on the wrap cycle
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int                CNT_W = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] r_cnt;

  // Combinational from the count so the owner sees the tick in the same cycle as the wrap
  assign tick = en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/turn_timer_ctrl.sv
// rtl/turn_timer_ctrl.sv - turn owner tracking and per-turn countdown with timeout pulse
// Optional countdown freeze on pause: TURN_TIMER_PAUSE_EN
module turn_timer_ctrl
  import turn_timer_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TURN_SECONDS = 15,
  parameter int WARN_SECONDS = 5
) (
  input  logic               clk,
  input  logic               rst,
  turn_timer_ctrl_if.slave   bus
);

  localparam logic [1:0]        ST_IDLE     = IDLE;
  localparam logic [1:0]        ST_RUN      = RUN;
  localparam logic [1:0]        ST_EXPIRE   = EXPIRE;
  localparam logic [SECS_W-1:0] SECS_RELOAD = SECS_W'(TURN_SECONDS);
  localparam logic [SECS_W-1:0] SECS_WARN   = SECS_W'(WARN_SECONDS);

  logic [1:0]        r_state;
  logic              r_finished;
  logic              r_owner;
  logic              r_running;
  logic              r_warn;
  logic [SECS_W-1:0] r_secs;

  logic              w_tick;
  logic              w_clr;
  logic              w_en;
  logic [SECS_W-1:0] w_secs_dec;

  // Prescaler only runs inside a live turn; any exit from RUN restarts it from zero
  assign w_clr      = (r_state != ST_RUN) || bus.new_game || bus.move_done;
  assign w_secs_dec = r_secs - SECS_W'(1);

`ifdef TURN_TIMER_PAUSE_EN
  assign w_en = !bus.pause;
`else
  logic w_unused_pause;
  assign w_unused_pause = bus.pause;
  assign w_en           = 1'b1;
`endif

  tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .en   (w_en),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_finished <= 1'b0;
      r_owner    <= OWNER_P1;
      r_running  <= 1'b0;
      r_warn     <= 1'b0;
      r_secs     <= SECS_RELOAD;
    end else begin
      r_finished <= 1'b0;
      if (bus.new_game) begin
        r_state   <= ST_IDLE;
        r_owner   <= bus.first_player;
        r_running <= 1'b0;
        r_warn    <= 1'b0;
        r_secs    <= SECS_RELOAD;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.start) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
              r_secs    <= SECS_RELOAD;
              r_warn    <= (SECS_RELOAD <= SECS_WARN);
            end
          end
          ST_RUN: begin
            if (bus.move_done) begin
              r_state   <= ST_IDLE;
              r_owner   <= !r_owner;
              r_running <= 1'b0;
              r_warn    <= 1'b0;
              r_secs    <= SECS_RELOAD;
            end else if (w_tick) begin
              if (r_secs > SECS_W'(1)) begin
                r_secs <= w_secs_dec;
                r_warn <= (w_secs_dec <= SECS_WARN);
              end else begin
                r_state    <= ST_EXPIRE;
                r_secs     <= '0;
                r_finished <= 1'b1;
                r_running  <= 1'b0;
                r_warn     <= 1'b0;
              end
            end
          end
          ST_EXPIRE: begin
            r_state <= ST_IDLE;
            r_owner <= !r_owner;
            r_secs  <= SECS_RELOAD;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.finished     = r_finished;
  assign bus.turn_owner   = r_owner;
  assign bus.running      = r_running;
  assign bus.seconds_left = r_secs;
  assign bus.warn         = r_warn;

endmodule

// File: tb/tb_turn_timer_ctrl.sv
// tb/tb_turn_timer_ctrl.sv - vector table, corner sequences and random run against an elapsed-time model
module tb_turn_timer_ctrl;

  localparam int HZ = 10;
  localparam int TS = 3;
  localparam int WS = 1;
`ifdef TURN_TIMER_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  turn_timer_ctrl_if bus ();

  turn_timer_ctrl #(
    .CLK_HZ       (HZ),
    .TURN_SECONDS (TS),
    .WARN_SECONDS (WS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      name;
    logic       ng, fp, st, md, pz;
    int         ncyc;
    logic       fin, own, run;
    logic [4:0] secs;
    logic       warn;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_mis = 0;

  // Model: phase 0 idle / 1 run / 2 expire, plus cycles of unpaused run time
  int   m_phase;
  int   m_elapsed;
  logic m_owner;
  int   k;
  int   fin_k;

  task automatic add(string name, logic ng, logic fp, logic st, logic md, logic pz, int ncyc,
                     logic fin, logic own, logic run, logic [4:0] secs, logic warn);
    vec_t v;
    v.name = name; v.ng = ng; v.fp = fp; v.st = st; v.md = md; v.pz = pz; v.ncyc = ncyc;
    v.fin = fin; v.own = own; v.run = run; v.secs = secs; v.warn = warn;
    vq.push_back(v);
  endtask

  task automatic set_in(logic ng, logic fp, logic st, logic md, logic pz);
    bus.new_game = ng; bus.first_player = fp; bus.start = st; bus.move_done = md; bus.pause = pz;
  endtask

  task automatic check(string name, logic ef, logic eo, logic er, logic [4:0] es, logic ew);
    n_vec++;
    if ({bus.finished, bus.turn_owner, bus.running, bus.seconds_left, bus.warn} !== {ef, eo, er, es, ew}) begin
      n_mis++;
      $display("FAIL %s: got fin=%b own=%b run=%b secs=%0d warn=%b, want fin=%b own=%b run=%b secs=%0d warn=%b",
               name, bus.finished, bus.turn_owner, bus.running, bus.seconds_left, bus.warn, ef, eo, er, es, ew);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_owner = 1'b0;
  endtask

  task automatic model_step();
    if (bus.new_game) begin
      m_phase = 0; m_owner = bus.first_player; m_elapsed = 0;
    end else if (m_phase == 1) begin
      if (bus.move_done) begin
        m_phase = 0; m_owner = !m_owner;
      end else if (!(PAUSE_EN && bus.pause)) begin
        m_elapsed++;
        if (m_elapsed == TS * HZ) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      m_phase = 0; m_owner = !m_owner;
    end else if (bus.start) begin
      m_phase = 1; m_elapsed = 0;
    end
  endtask

  task automatic model_check(string name);
    int secs;
    secs = (m_phase == 1) ? TS - m_elapsed / HZ : (m_phase == 2) ? 0 : TS;
    check(name, m_phase == 2, m_owner, m_phase == 1, 5'(secs), (m_phase == 1) && (secs <= WS));
  endtask

  task automatic step(string name);
    model_step();
    @(posedge clk);
    #1;
    model_check(name);
  endtask

  task automatic pstep();
    step("pause_seq");
    k++;
    if (bus.finished === 1'b1 && fin_k < 0) fin_k = k;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("reset", 0, 0, 0, 5'd3, 0);
    @(negedge clk);
    rst = 1'b1;

    //   name         ng fp st md pz  n   fin own run secs warn
    add("t_start",    0, 0, 1, 0, 0,  1,  0,  0,  1,  3,   0);
    add("t_hold3",    0, 0, 0, 0, 0,  9,  0,  0,  1,  3,   0);
    add("t_dec2",     0, 0, 0, 0, 0,  1,  0,  0,  1,  2,   0);
    add("t_dec1",     0, 0, 0, 0, 0, 10,  0,  0,  1,  1,   1);
    add("t_last1",    0, 0, 0, 0, 0,  9,  0,  0,  1,  1,   1);
    add("t_expire",   0, 0, 0, 0, 0,  1,  1,  0,  0,  0,   0);
    add("t_idle",     0, 0, 0, 0, 0,  1,  0,  1,  0,  3,   0);
    add("e_start",    0, 0, 1, 0, 0,  1,  0,  1,  1,  3,   0);
    add("e_run",      0, 0, 0, 0, 0, 11,  0,  1,  1,  2,   0);
    add("e_move",     0, 0, 0, 1, 0,  1,  0,  0,  0,  3,   0);
    add("s_start",    0, 0, 1, 0, 0,  1,  0,  0,  1,  3,   0);
    add("s_run",      0, 0, 0, 0, 0, 29,  0,  0,  1,  1,   1);
    add("s_move",     0, 0, 0, 1, 0,  1,  0,  1,  0,  3,   0);
    add("s_after",    0, 0, 0, 0, 0,  5,  0,  1,  0,  3,   0);
    add("ng_p1",      1, 0, 0, 0, 0,  1,  0,  0,  0,  3,   0);
    add("ng_start",   0, 0, 1, 0, 0,  1,  0,  0,  1,  3,   0);
    add("ng_run",     0, 0, 0, 0, 0, 14,  0,  0,  1,  2,   0);
    add("ng_mid",     1, 1, 0, 0, 0,  1,  0,  1,  0,  3,   0);
    add("ng_quiet",   0, 0, 0, 0, 0, 40,  0,  1,  0,  3,   0);
    add("hold_exp",   0, 0, 1, 0, 0, 31,  1,  1,  0,  0,   0);
    add("hold_idle",  0, 0, 1, 0, 0,  1,  0,  0,  0,  3,   0);
    add("hold_rerun", 0, 0, 1, 0, 0,  1,  0,  0,  1,  3,   0);
    add("md_prio",    0, 0, 1, 1, 0,  1,  0,  1,  0,  3,   0);
    add("md_idle",    0, 0, 0, 1, 0,  1,  0,  1,  0,  3,   0);
    add("x_start",    0, 0, 1, 0, 0,  1,  0,  1,  1,  3,   0);
    add("x_expire",   0, 0, 0, 0, 0, 30,  1,  1,  0,  0,   0);
    add("x_md_exp",   0, 0, 0, 1, 0,  1,  0,  0,  0,  3,   0);

    foreach (vq[i]) begin
      set_in(vq[i].ng, vq[i].fp, vq[i].st, vq[i].md, vq[i].pz);
      for (int c = 0; c < vq[i].ncyc; c++) step(vq[i].name);
      check(vq[i].name, vq[i].fin, vq[i].own, vq[i].run, vq[i].secs, vq[i].warn);
    end

    // Pause 25 cycles from the 10th cycle of a turn; finished edge counted from the start edge
    fin_k = -1;
    set_in(0, 0, 1, 0, 0);
    step("pause_seq");
    k = 0;
    set_in(0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) pstep();
    set_in(0, 0, 0, 0, 1);
    for (int i = 0; i < 25; i++) pstep();
    set_in(0, 0, 0, 0, 0);
    for (int i = 0; i < 60 && fin_k < 0; i++) pstep();
    n_vec++;
    if (fin_k != (PAUSE_EN ? 55 : 30)) begin
      n_mis++;
      $display("FAIL pause_delay: finished at edge %0d, want edge %0d", fin_k, PAUSE_EN ? 55 : 30);
    end
    step("pause_idle");

    // Asynchronous reset in the middle of a P2 turn
    set_in(0, 0, 1, 0, 0);
    step("ar_start");
    set_in(0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) step("ar_run");
    check("ar_pre", 0, 1, 1, 5'd2, 0);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", 0, 0, 0, 5'd3, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(99) < 2, 1'($urandom_range(1)), $urandom_range(99) < 15,
             $urandom_range(99) < 3, $urandom_range(99) < 25);
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
